// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the FSM state encoding, the zero-register address and the address-width helper.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_ZERO_ADDR = 0;

  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp. The master is the ID stage, and the slave is the register file.
// Handshake: ready is high only in RUN. A write or alloc is accepted on an edge where ready=1 and clr_req=0.
// At any other edge it is dropped, and there is no backpressure beyond that.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  localparam int AW = rf_addr_w(DEPTH);

  logic                    clr_req;
  logic                    ready;
  logic [NUM_RD-1:0]       re;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]       rbusy;
  logic [NUM_WR-1:0]       we;
  logic [NUM_WR*AW-1:0]    waddr;
  logic [NUM_WR*WIDTH-1:0] wdata;
  logic                    alloc_en;
  logic [AW-1:0]           alloc_addr;

  modport master (
    output clr_req, re, raddr, we, waddr, wdata, alloc_en, alloc_addr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  clr_req, re, raddr, we, waddr, wdata, alloc_en, alloc_addr,
    output ready, rdata, rbusy
  );
endinterface

// File: rtl/regfile_rd_port.sv
// A single read port of the register file.
// It applies the enable, zero-register and write-bypass priority to the array value and busy bit.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    run,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  input  logic [WIDTH-1:0]        reg_data,
  input  logic                    reg_busy,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    waddr,
  input  logic [NUM_WR*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rbusy
);
  logic             hit;
  logic [WIDTH-1:0] byp_data;

  always_comb begin
    rdata    = '0;
    rbusy    = 1'b0;
    hit      = 1'b0;
    byp_data = '0;
    if (run && re && !(ZERO_REG != 0 && raddr == AW'(RF_ZERO_ADDR))) begin
      // Later ports overwrite earlier matches, so the highest-numbered writer wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && waddr[w*AW +: AW] == raddr) begin
          hit      = 1'b1;
          byp_data = wdata[w*WIDTH +: WIDTH];
        end
      end
      rdata = hit ? byp_data : reg_data;
      rbusy = hit ? 1'b0 : reg_busy;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// GeMIPS ID-stage register file with parametrised read and write ports.
// It provides write bypass, a busy scoreboard and a one-entry-per-cycle clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus,
  output rf_state_e   dbg_state
);
  localparam int AW = rf_addr_w(DEPTH);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    clr_idx_q;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic             run;
  logic             accept;

  assign run       = (state_q == RF_RUN);
  assign accept    = run && !bus.clr_req;
  assign bus.ready = run;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_CLEAR: if (clr_idx_q == AW'(DEPTH - 1)) state_d = RF_RUN;
      RF_RUN:   if (bus.clr_req) state_d = RF_CLEAR;
      default:  state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (!run) clr_idx_q <= clr_idx_q + 1'b1;
      else if (bus.clr_req) clr_idx_q <= '0;
    end
  end

  // The array has no reset, and it reaches zero only through the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        regs[clr_idx_q] <= '0;
      end else if (accept) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.we[w] && !(ZERO_REG != 0 && bus.waddr[w*AW +: AW] == AW'(RF_ZERO_ADDR)))
            regs[bus.waddr[w*AW +: AW]] <= bus.wdata[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // The alloc is assigned after the commits, so a same-edge alloc leaves the register busy.
  always_ff @(posedge clk) begin
    if (!rst || (run && bus.clr_req)) begin
      busy_q <= '0;
    end else if (run) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.we[w]) busy_q[bus.waddr[w*AW +: AW]] <= 1'b0;
      end
      if (bus.alloc_en && !(ZERO_REG != 0 && bus.alloc_addr == AW'(RF_ZERO_ADDR)))
        busy_q[bus.alloc_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.raddr[p*AW +: AW];

    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .run      (run),
      .re       (bus.re[p]),
      .raddr    (ra),
      .reg_data (regs[ra]),
      .reg_busy (busy_q[ra]),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (bus.rdata[p*WIDTH +: WIDTH]),
      .rbusy    (bus.rbusy[p])
    );
  end
endmodule
